// File: rtl/nor_test_pkg.sv
// Shared types and helpers for rail-driven gate exercisers.
// Holds the sweep FSM encoding, the valid rail code and the NOR reference.
package nor_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Rails are only trustworthy when the logic-1 rail is high and the logic-0 rail is low.
  localparam logic [1:0] RAIL_VALID = 2'b10;

  // Widest supported pattern plus the terminal guard bit; callers zero-extend.
  localparam int PATTERN_MAX_W = 17;

  function automatic logic nor_expected(input logic [PATTERN_MAX_W-1:0] pattern);
    return (pattern == '0);
  endfunction

endpackage

// File: rtl/rail_bus_driver.sv
// Drives a pattern onto a gate input bus using the supply rails as the bit sources.
// The bus floats whenever enable is low so the gate can be shared.
module rail_bus_driver #(
  parameter int INPUT_WIDTH = 1
) (
  input  logic [1:0]             DigitSupply,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] pattern,
  output tri   [INPUT_WIDTH-1:0] driveData
);

  logic [INPUT_WIDTH-1:0] rail_bits;

  // Each bit is taken from a rail rather than a constant, so rail faults reach the gate.
  generate
    for (genvar gi = 0; gi < INPUT_WIDTH; gi++) begin : g_bit
      assign rail_bits[gi] = pattern[gi] ? DigitSupply[1] : DigitSupply[0];
    end
  endgenerate

  assign driveData = enable ? rail_bits : {INPUT_WIDTH{1'bz}};

endmodule

// File: rtl/nor_gate_exerciser.sv
// Sweeps every input pattern of a rail-supplied NOR gate and checks its output.
// Reports mismatch count, first failing pattern and aborts on invalid rails.
module nor_gate_exerciser
  import nor_test_pkg::*;
#(
  parameter int INPUT_WIDTH   = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_WIDTH     = INPUT_WIDTH + 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [1:0]             DigitSupply,
  input  logic                   start,
  output tri   [INPUT_WIDTH-1:0] driveData,
  input  logic                   sampleData,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_WIDTH-1:0]   errorCount,
  output logic                   failValid,
  output logic [INPUT_WIDTH-1:0] firstFailPattern,
  output logic                   railError
);

  localparam logic [INPUT_WIDTH:0] LAST_PATTERN = {1'b0, {INPUT_WIDTH{1'b1}}};
  localparam logic [7:0]           SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);

  state_e                 state_q;
  logic [INPUT_WIDTH:0]   pattern_q;
  logic [7:0]             settle_q;
  logic                   busy_q;
  logic                   done_q;
  logic [ERR_WIDTH-1:0]   err_q;
  logic                   fail_valid_q;
  logic [INPUT_WIDTH-1:0] first_fail_q;
  logic                   rail_err_q;

  logic expected_d;
  logic mismatch_d;

  assign expected_d = nor_expected(PATTERN_MAX_W'(pattern_q));
  // Case-inequality so an undriven or unknown gate output is reported as a failure.
  assign mismatch_d = (sampleData !== expected_d);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      rail_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (DigitSupply != RAIL_VALID) begin
              rail_err_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= ST_FINISH;
            end else begin
              err_q        <= '0;
              fail_valid_q <= 1'b0;
              first_fail_q <= '0;
              rail_err_q   <= 1'b0;
              pattern_q    <= '0;
              busy_q       <= 1'b1;
              state_q      <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          settle_q <= SETTLE_LOAD;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch_d) begin
            if (err_q != '1) begin
              err_q <= err_q + 1'b1;
            end
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              first_fail_q <= pattern_q[INPUT_WIDTH-1:0];
            end
          end
          if (pattern_q == LAST_PATTERN) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            pattern_q <= pattern_q + 1'b1;
            state_q   <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy_q tracks exactly the sweep states, so it doubles as the bus enable.
  rail_bus_driver #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_driver (
    .DigitSupply(DigitSupply),
    .enable     (busy_q),
    .pattern    (pattern_q[INPUT_WIDTH-1:0]),
    .driveData  (driveData)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign errorCount       = err_q;
  assign failValid        = fail_valid_q;
  assign firstFailPattern = first_fail_q;
  assign railError        = rail_err_q;

endmodule

// File: tb/tb_nor_gate_exerciser.sv
// Randomized bench for nor_gate_exerciser with a fault-injecting NOR gate model.
// Expected results are derived from the per-pattern fault mask and rail code.
module tb_nor_gate_exerciser;

  localparam int W   = 2;
  localparam int S   = 2;
  localparam int EW  = W + 1;
  localparam int NP  = 1 << W;
  localparam int PAT_CYC = S + 2;

  logic          clk;
  logic          rst;
  logic [1:0]    rails;
  logic          start;
  wire  [W-1:0]  drive_data;
  logic          sample_data;
  logic          busy;
  logic          done;
  logic [EW-1:0] err_cnt;
  logic          fail_valid;
  logic [W-1:0]  first_fail;
  logic          rail_err;

  logic [NP-1:0] flip_mask;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_err;
  int exp_first;
  int exp_fv;
  int exp_rail;

  nor_gate_exerciser #(
    .INPUT_WIDTH  (W),
    .SETTLE_CYCLES(S),
    .ERR_WIDTH    (EW)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .DigitSupply     (rails),
    .start           (start),
    .driveData       (drive_data),
    .sampleData      (sample_data),
    .busy            (busy),
    .done            (done),
    .errorCount      (err_cnt),
    .failValid       (fail_valid),
    .firstFailPattern(first_fail),
    .railError       (rail_err)
  );

  // The gate under test: a NOR of the bus, optionally inverted per input pattern.
  assign sample_data = (~|drive_data) ^ flip_mask[drive_data];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, ".errorCount"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, ".failValid"}, 32'(fail_valid), 32'(exp_fv));
    chk({tag, ".firstFail"}, 32'(first_fail), 32'(exp_first));
    chk({tag, ".railError"}, 32'(rail_err), 32'(exp_rail));
  endtask

  // Reference: a valid-rail sweep reports every inverted pattern; a rail fault only flags railError.
  task automatic model_sweep(input logic [NP-1:0] flip, input logic [1:0] rl);
    if (rl != 2'b10) begin
      exp_rail = 1;
    end else begin
      exp_rail  = 0;
      exp_err   = 0;
      exp_fv    = 0;
      exp_first = 0;
      for (int p = 0; p < NP; p++) begin
        if (flip[p]) begin
          if (exp_fv == 0) begin
            exp_fv    = 1;
            exp_first = p;
          end
          exp_err++;
        end
      end
    end
  endtask

  // Runs one start pulse at a negedge; restart_at >= 0 re-pulses start that many busy cycles in.
  task automatic run_sweep(input string tag, input logic [NP-1:0] flip, input logic [1:0] rl,
                           input int idle_cycles, input int restart_at);
    int cycles;
    int exp_busy;
    flip_mask = flip;
    rails     = rl;
    repeat (idle_cycles) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      chk({tag, ".pattern"}, 32'(drive_data), 32'(cycles / PAT_CYC));
      chk({tag, ".done_low"}, 32'(done), 32'd0);
      start = (cycles == restart_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
    exp_busy = (rl == 2'b10) ? NP * PAT_CYC : 0;
    model_sweep(flip, rl);
    chk({tag, ".busy_cycles"}, 32'(cycles), 32'(exp_busy));
    chk({tag, ".done_pulse"}, 32'(done), 32'd1);
    check_results(tag);
    @(negedge clk);
    chk({tag, ".done_end"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    $display("[TB] %s flip=%b rails=%b busy=%0d err=%0d first=%0d fv=%0d railErr=%0d",
             tag, flip, rl, cycles, err_cnt, first_fail, fail_valid, rail_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    exp_err = 0; exp_fv = 0; exp_first = 0; exp_rail = 0;
    check_results(tag);
  endtask

  initial begin
    logic [1:0]    rl;
    logic [NP-1:0] fl;
    int            ra;
    int            done_seen;

    rst = 1'b1; start = 1'b0; rails = 2'b10; flip_mask = '0;
    exp_err = 0; exp_fv = 0; exp_first = 0; exp_rail = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_sweep("clean", 4'b0000, 2'b10, 1, -1);
    run_sweep("tied0", 4'b0001, 2'b10, 0, -1);
    run_sweep("tied1", 4'b1110, 2'b10, 2, -1);
    run_sweep("rail00", 4'b0000, 2'b00, 1, -1);
    run_sweep("restart", 4'b0100, 2'b10, 0, 6);

    // Reset five cycles into a sweep: immediate abort, no done pulse.
    rails = 2'b10; flip_mask = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("midreset.quiet", 32'(done_seen), 32'd0);
    run_sweep("after_reset", 4'b0000, 2'b10, 0, -1);

    // Start and Reset together: reset wins and the FSM stays idle.
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check_reset_outputs("start_rst");
    @(negedge clk);
    chk("start_rst.idle", 32'(busy), 32'd0);

    for (int it = 0; it < 24; it++) begin
      fl = NP'($urandom_range(0, (1 << NP) - 1));
      rl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b10;
      if (rl == 2'b10 && $urandom_range(0, 3) == 0) rl = 2'b11;
      ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NP * PAT_CYC - 1)) : -1;
      run_sweep($sformatf("rand%0d", it), fl, rl, int'($urandom_range(0, 3)), ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
